// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - phase drive type and forward hall commutation table for the BLDC drive
package bldc_pkg;

    typedef enum logic [1:0] {
        PH_OFF = 2'd0,
        PH_HI  = 2'd1,
        PH_LO  = 2'd2
    } ph_t;

    typedef struct packed {
        ph_t a;
        ph_t b;
        ph_t c;
    } drive_t;

    // Indexed by hall code {h1,h2,h3}; 000 and 111 are illegal and drive nothing.
    localparam drive_t FWD_TBL [8] = '{
        '{PH_OFF, PH_OFF, PH_OFF},
        '{PH_OFF, PH_LO,  PH_HI },
        '{PH_LO,  PH_HI,  PH_OFF},
        '{PH_LO,  PH_OFF, PH_HI },
        '{PH_HI,  PH_OFF, PH_LO },
        '{PH_HI,  PH_LO,  PH_OFF},
        '{PH_OFF, PH_HI,  PH_LO },
        '{PH_OFF, PH_OFF, PH_OFF}
    };

    function automatic ph_t ph_swap(input ph_t p);
        case (p)
            PH_HI:   return PH_LO;
            PH_LO:   return PH_HI;
            default: return PH_OFF;
        endcase
    endfunction

    function automatic logic hall_legal(input logic [2:0] h);
        return (h != 3'b000) && (h != 3'b111);
    endfunction

endpackage

// File: rtl/bldc_drive_ctrl_deadtime.sv
// rtl/bldc_drive_ctrl_deadtime.sv - per-phase dead-time insertion between high and low gate drives
module bldc_deadtime #(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_hi,
    input  logic i_req_lo,
    output logic o_q_hi,
    output logic o_q_lo
);
    localparam int CW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

    logic [CW-1:0] r_hi_off;
    logic [CW-1:0] r_lo_off;
    logic          r_q_hi;
    logic          r_q_lo;
    logic          w_hi_ok;
    logic          w_lo_ok;

    // A side may rise once its complement has been low for DEADTIME full cycles.
    assign w_hi_ok = (DEADTIME == 0) || (!r_q_lo && (int'(r_lo_off) + 1 >= DEADTIME));
    assign w_lo_ok = (DEADTIME == 0) || (!r_q_hi && (int'(r_hi_off) + 1 >= DEADTIME));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_hi   <= 1'b0;
            r_q_lo   <= 1'b0;
            r_hi_off <= '0;
            r_lo_off <= '0;
        end else begin
            r_q_hi <= i_req_hi && !i_req_lo && w_hi_ok;
            r_q_lo <= i_req_lo && !i_req_hi && w_lo_ok;
            if (r_q_lo)
                r_lo_off <= '0;
            else if (int'(r_lo_off) < DEADTIME)
                r_lo_off <= r_lo_off + 1'b1;
            if (r_q_hi)
                r_hi_off <= '0;
            else if (int'(r_hi_off) < DEADTIME)
                r_hi_off <= r_hi_off + 1'b1;
        end
    end

    assign o_q_hi = r_q_hi;
    assign o_q_lo = r_q_lo;

endmodule

// File: rtl/bldc_drive_ctrl.sv
// rtl/bldc_drive_ctrl.sv - BLDC six-gate drive: PWM, duty ramp, hall filter, commutation, fault
module bldc_drive_ctrl
    import bldc_pkg::*;
#(
    parameter int DUTY_W    = 8,
    parameter int PWM_DIV   = 1,
    parameter int DEADTIME  = 4,
    parameter int RAMP_STEP = 0,
    parameter int HALL_FILT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_cmd,
    input  logic              h1,
    input  logic              h2,
    input  logic              h3,
    input  logic              fault_clr,
    output logic              Q1H,
    output logic              Q1L,
    output logic              Q2H,
    output logic              Q2L,
    output logic              Q3H,
    output logic              Q3L,
    output logic              fault,
    output logic              dir_applied,
    output logic [DUTY_W-2:0] duty_applied,
    output logic              pwm_sync
);
    localparam int MW       = DUTY_W - 1;
    localparam int PMAX     = (1 << MW) - 1;
    localparam int DW       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int HW       = (HALL_FILT > 1) ? $clog2(HALL_FILT + 1) : 1;
    localparam int STEP_SAT = (RAMP_STEP > PMAX) ? PMAX : RAMP_STEP;
    localparam logic [MW-1:0] P_LAST = MW'(PMAX - 1);
    localparam logic [MW-1:0] STEP_V = MW'(STEP_SAT);

    logic [DW-1:0] r_div;
    logic [MW-1:0] r_cnt;
    logic          r_sync;
    logic [MW-1:0] r_duty;
    logic          r_dir;
    logic [2:0]    r_hs1;
    logic [2:0]    r_hs2;
    logic [2:0]    r_cand;
    logic [HW-1:0] r_hcnt;
    logic [2:0]    r_hfilt;
    logic          r_seen;
    logic          r_fault;

    logic          w_step;
    logic          w_wrap;
    logic          w_tgt_dir;
    logic [MW-1:0] w_tgt_mag;
    logic [MW-1:0] w_duty_nxt;
    logic          w_dir_nxt;
    logic          w_pwm_on;
    logic          w_gate_en;
    drive_t        w_drive;
    ph_t           w_ph [3];
    logic [2:0]    w_q_hi;
    logic [2:0]    w_q_lo;

    assign w_step    = (r_div == DW'(PWM_DIV - 1));
    assign w_wrap    = w_step && (r_cnt == P_LAST);
    assign w_tgt_dir = duty_cmd[DUTY_W-1];
    assign w_tgt_mag = duty_cmd[MW-1:0];
    assign w_pwm_on  = (r_duty > r_cnt);
    assign w_gate_en = en && !r_fault;

    // Ramp only moves on period boundaries; a reversal bleeds to zero before the direction flips.
    always_comb begin
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir;
        if (!en) begin
            w_duty_nxt = '0;
            w_dir_nxt  = w_tgt_dir;
        end else if (RAMP_STEP == 0) begin
            w_duty_nxt = w_tgt_mag;
            w_dir_nxt  = w_tgt_dir;
        end else if (w_wrap) begin
            if (w_tgt_dir != r_dir) begin
                if (r_duty == '0)
                    w_dir_nxt = w_tgt_dir;
                else if (r_duty > STEP_V)
                    w_duty_nxt = r_duty - STEP_V;
                else
                    w_duty_nxt = '0;
            end else if (r_duty < w_tgt_mag) begin
                w_duty_nxt = (w_tgt_mag - r_duty > STEP_V) ? r_duty + STEP_V : w_tgt_mag;
            end else if (r_duty > w_tgt_mag) begin
                w_duty_nxt = (r_duty - w_tgt_mag > STEP_V) ? r_duty - STEP_V : w_tgt_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_cnt   <= '0;
            r_sync  <= 1'b0;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_hs1   <= 3'b000;
            r_hs2   <= 3'b000;
            r_cand  <= 3'b000;
            r_hcnt  <= '0;
            r_hfilt <= 3'b000;
            r_seen  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_div  <= w_step ? '0 : r_div + 1'b1;
            if (w_step)
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_sync <= w_wrap;
            r_duty <= w_duty_nxt;
            r_dir  <= w_dir_nxt;

            r_hs1 <= {h1, h2, h3};
            r_hs2 <= r_hs1;
            if (r_hs2 != r_cand) begin
                r_cand <= r_hs2;
                r_hcnt <= HW'(1);
            end else if (int'(r_hcnt) < HALL_FILT) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            if (int'(r_hcnt) >= HALL_FILT)
                r_hfilt <= r_cand;

            if (hall_legal(r_hfilt))
                r_seen <= 1'b1;
            // Set has priority over clear; clear needs a legal filtered code.
            if (r_seen && !hall_legal(r_hfilt))
                r_fault <= 1'b1;
            else if (fault_clr && hall_legal(r_hfilt))
                r_fault <= 1'b0;
        end
    end

    always_comb begin
        w_drive = FWD_TBL[r_hfilt];
        w_ph[0] = r_dir ? ph_swap(w_drive.a) : w_drive.a;
        w_ph[1] = r_dir ? ph_swap(w_drive.b) : w_drive.b;
        w_ph[2] = r_dir ? ph_swap(w_drive.c) : w_drive.c;
    end

    for (genvar g = 0; g < 3; g++) begin : g_phase
        bldc_deadtime #(
            .DEADTIME(DEADTIME)
        ) u_dt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_req_hi(w_gate_en && (w_ph[g] == PH_HI) && w_pwm_on),
            .i_req_lo(w_gate_en && (w_ph[g] == PH_LO)),
            .o_q_hi  (w_q_hi[g]),
            .o_q_lo  (w_q_lo[g])
        );
    end

    assign Q1H          = w_q_hi[0];
    assign Q1L          = w_q_lo[0];
    assign Q2H          = w_q_hi[1];
    assign Q2L          = w_q_lo[1];
    assign Q3H          = w_q_hi[2];
    assign Q3L          = w_q_lo[2];
    assign fault        = r_fault;
    assign dir_applied  = r_dir;
    assign duty_applied = r_duty;
    assign pwm_sync     = r_sync;

endmodule
